// File: rtl/io_bus_router_pkg.sv
// Shared definitions for the I/O bus router: slave indices, decode windows,
// FSM state encoding and small helpers.
package io_bus_router_pkg;

    localparam int unsigned NUM_SLAVES = 4;

    localparam int unsigned SLV_PIC = 0;
    localparam int unsigned SLV_PIT = 1;
    localparam int unsigned SLV_PS2 = 2;
    localparam int unsigned SLV_RTC = 3;

    localparam logic [15:0] ADDR_PIC_MASTER = 16'h0020;
    localparam logic [15:0] ADDR_PIC_SLAVE  = 16'h00A0;
    localparam logic [15:0] ADDR_PIT        = 16'h0040;
    localparam logic [15:0] ADDR_PS2_DATA   = 16'h0060;
    localparam logic [15:0] ADDR_PS2_CTRL   = 16'h0064;
    localparam logic [15:0] ADDR_RTC        = 16'h0070;

    // Returned for unmapped reads and for reads abandoned by the stall timeout.
    localparam logic [31:0] DATA_UNMAPPED = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        StIdle,
        StFwd,
        StWaitData,
        StResp
    } state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/io_addr_decode.sv
// Combinational address decoder: one-hot slave select plus an unmapped flag.
module io_addr_decode
    import io_bus_router_pkg::*;
(
    input  logic [15:0] i_address,
    output logic [3:0]  o_sel,
    output logic        o_unmapped
);

    always_comb begin
        o_sel      = '0;
        o_unmapped = 1'b0;
        unique case (i_address)
            ADDR_PIC_MASTER, ADDR_PIC_SLAVE: o_sel[SLV_PIC] = 1'b1;
            ADDR_PIT:                        o_sel[SLV_PIT] = 1'b1;
            ADDR_PS2_DATA, ADDR_PS2_CTRL:    o_sel[SLV_PS2] = 1'b1;
            ADDR_RTC:                        o_sel[SLV_RTC] = 1'b1;
            default:                         o_unmapped     = 1'b1;
        endcase
    end

endmodule

// File: rtl/io_bus_router.sv
// Single-outstanding Avalon I/O router: forwards one master command to one of four
// legacy slaves, returns read data, and force-completes stalled accesses.
module io_bus_router
    import io_bus_router_pkg::*;
#(
    parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [15:0]  avalon_io_address,
    input  logic [3:0]   avalon_io_byteenable,
    input  logic         avalon_io_read,
    input  logic         avalon_io_write,
    input  logic [31:0]  avalon_io_writedata,
    output logic         avalon_io_waitrequest,
    output logic         avalon_io_readdatavalid,
    output logic [31:0]  avalon_io_readdata,
    output logic [15:0]  slv_address,
    output logic [3:0]   slv_byteenable,
    output logic [31:0]  slv_writedata,
    output logic [3:0]   slv_read,
    output logic [3:0]   slv_write,
    input  logic [3:0]   slv_waitrequest,
    input  logic [3:0]   slv_readdatavalid,
    input  logic [127:0] slv_readdata,
    output logic [7:0]   timeout_count
);

    state_e      r_state;
    state_e      w_state_next;
    logic [15:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [3:0]  r_sel;
    logic        r_write;
    logic        r_unmapped;
    logic [7:0]  r_stall;
    logic [7:0]  r_tcount;
    logic [31:0] r_rdata;

    logic [3:0]  w_dec_sel;
    logic        w_dec_unmapped;
    logic        w_capture;
    logic        w_load_rdata;
    logic        w_timeout;
    logic [31:0] w_rdata_next;
    logic        w_sel_wait;
    logic        w_sel_rdv;
    logic        w_stall_max;
    logic [31:0] w_sel_data;

    io_addr_decode u_decode (
        .i_address  (avalon_io_address),
        .o_sel      (w_dec_sel),
        .o_unmapped (w_dec_unmapped)
    );

    // r_sel is all-zero for unmapped accesses, so these reduce to 0 there.
    assign w_sel_wait  = |(r_sel & slv_waitrequest);
    assign w_sel_rdv   = |(r_sel & slv_readdatavalid);
    assign w_stall_max = (r_stall == TIMEOUT_CYCLES);
    assign w_sel_data  = ({32{r_sel[SLV_PIC]}} & slv_readdata[32*SLV_PIC +: 32])
                       | ({32{r_sel[SLV_PIT]}} & slv_readdata[32*SLV_PIT +: 32])
                       | ({32{r_sel[SLV_PS2]}} & slv_readdata[32*SLV_PS2 +: 32])
                       | ({32{r_sel[SLV_RTC]}} & slv_readdata[32*SLV_RTC +: 32]);

    always_comb begin
        w_state_next          = r_state;
        avalon_io_waitrequest = 1'b1;
        w_capture             = 1'b0;
        w_load_rdata          = 1'b0;
        w_rdata_next          = r_rdata;
        w_timeout             = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (avalon_io_write || avalon_io_read) begin
                    w_capture    = 1'b1;
                    w_state_next = StFwd;
                end
            end
            StFwd: begin
                if (r_unmapped || !w_sel_wait || w_stall_max) begin
                    avalon_io_waitrequest = 1'b0;
                    // Only an ack the slave never granted counts as forced.
                    w_timeout = !r_unmapped && w_sel_wait;
                    if (r_write) begin
                        w_state_next = StIdle;
                    end else if (r_unmapped || (w_timeout && !w_sel_rdv)) begin
                        w_load_rdata = 1'b1;
                        w_rdata_next = DATA_UNMAPPED;
                        w_state_next = StResp;
                    end else if (w_sel_rdv) begin
                        w_load_rdata = 1'b1;
                        w_rdata_next = w_sel_data;
                        w_state_next = StResp;
                    end else begin
                        w_state_next = StWaitData;
                    end
                end
            end
            StWaitData: begin
                if (w_sel_rdv) begin
                    w_load_rdata = 1'b1;
                    w_rdata_next = w_sel_data;
                    w_state_next = StResp;
                end else if (w_stall_max) begin
                    w_load_rdata = 1'b1;
                    w_rdata_next = DATA_UNMAPPED;
                    w_timeout    = 1'b1;
                    w_state_next = StResp;
                end
            end
            StResp: begin
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        slv_read  = '0;
        slv_write = '0;
        if (r_state == StFwd) begin
            if (r_write) begin
                slv_write = r_sel;
            end else begin
                slv_read = r_sel;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_addr     <= '0;
            r_be       <= '0;
            r_wdata    <= '0;
            r_sel      <= '0;
            r_write    <= 1'b0;
            r_unmapped <= 1'b0;
            r_stall    <= '0;
            r_tcount   <= '0;
            r_rdata    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_capture) begin
                r_addr     <= avalon_io_address;
                r_be       <= avalon_io_byteenable;
                r_wdata    <= avalon_io_writedata;
                r_sel      <= w_dec_sel;
                r_unmapped <= w_dec_unmapped;
                r_write    <= avalon_io_write;
                r_stall    <= '0;
            end else if ((r_state == StFwd || r_state == StWaitData) && !w_stall_max) begin
                r_stall <= r_stall + 8'd1;
            end
            if (w_load_rdata) begin
                r_rdata <= w_rdata_next;
            end
            if (w_timeout) begin
                r_tcount <= sat_inc8(r_tcount);
            end
        end
    end

    assign avalon_io_readdatavalid = (r_state == StResp);
    assign avalon_io_readdata      = r_rdata;
    assign slv_address             = r_addr;
    assign slv_byteenable          = r_be;
    assign slv_writedata           = r_wdata;
    assign timeout_count           = r_tcount;

endmodule

// File: doc/io_bus_router.md
IO_BUS_ROUTER -- requirements
Module: io_bus_router

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 8'd255, cycles a selected slave may stall before forced completion.
REQ-002 SHALL have port clk  input  1  single clock for all state.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports avalon_io_address/avalon_io_byteenable/avalon_io_read/avalon_io_write/avalon_io_writedata  input  16/4/1/1/32  upstream master command, word-aligned address.
REQ-005 SHALL have ports avalon_io_waitrequest/avalon_io_readdatavalid/avalon_io_readdata  output  1/1/32  upstream master response.
REQ-006 SHALL have ports slv_address/slv_byteenable/slv_writedata  output  16/4/32  shared registered command to all slaves.
REQ-007 SHALL have ports slv_read/slv_write  output  4/4  one-hot per-slave strobes (0 PIC, 1 PIT, 2 PS/2, 3 RTC).
REQ-008 SHALL have ports slv_waitrequest/slv_readdatavalid  input  4/4  per-slave handshakes.
REQ-009 SHALL have port slv_readdata  input  128  slave n data at bits [32n+31:32n].
REQ-010 SHALL have port timeout_count  output  8  saturating count of forced completions.

Function
REQ-011 SHALL decode: 0x0020,0x00A0 -> slave 0; 0x0040 -> slave 1; 0x0060,0x0064 -> slave 2; 0x0070 -> slave 3; any other address -> unmapped.
REQ-012 SHALL implement states IDLE, FWD, WAIT_DATA, RESP.
REQ-013 IDLE: on avalon_io_write (priority) or avalon_io_read, SHALL register address, byteenable, writedata, slave select, direction, clear stall counter, go FWD; no slave strobe in IDLE.
REQ-014 FWD: SHALL drive slv_read/slv_write bit of selected slave only; unmapped drives no strobe.
REQ-015 avalon_io_waitrequest SHALL be 1 except in FWD when selected slv_waitrequest is 0, access unmapped, or stall counter equals TIMEOUT_CYCLES (ack cycle, combinational).
REQ-016 On FWD ack: write -> IDLE; mapped read -> WAIT_DATA; unmapped read -> RESP with data 32'hFFFFFFFF.
REQ-017 WAIT_DATA: on selected slv_readdatavalid SHALL register its slv_readdata and go RESP; readdatavalid of non-selected slaves SHALL be ignored.
REQ-018 readdatavalid arriving in the FWD ack cycle SHALL be captured and go directly RESP.
REQ-019 RESP: avalon_io_readdatavalid SHALL be 1 for exactly one cycle with registered data, then IDLE; avalon_io_readdata SHALL hold its last value otherwise.
REQ-020 Stall counter SHALL increment each cycle in FWD and WAIT_DATA; reaching TIMEOUT_CYCLES SHALL force ack (FWD) or RESP with 32'hFFFFFFFF (WAIT_DATA) and increment timeout_count, saturating at 8'hFF.
REQ-021 At most one transaction outstanding; master commands outside IDLE SHALL not be re-captured.
REQ-022 Minimum read latency: command accepted cycle T (IDLE capture T, ack T+1 earliest), readdatavalid T+3 for zero-wait slave.

Reset
REQ-023 rst_n low SHALL asynchronously force IDLE, all strobes 0, waitrequest 1, readdatavalid 0, readdata 0, slv_address/byteenable/writedata 0, counters 0.
REQ-024 Reset mid-transaction SHALL abandon it with no response; slave late readdatavalid after reset SHALL be ignored in IDLE.

Structure
REQ-025 Slave index constants, decode windows, state encodings SHALL live in the shared defines package.
REQ-026 Address decode SHALL be one combinational sub-module io_addr_decode (address in, 4-bit one-hot plus unmapped flag out).

Verification
REQ-027 Write 0x00000011 to 0x0020 be 4'b0001, PIC waitrequest 0 -> slv_write=4'b0001 one cycle, avalon_io_waitrequest low that cycle, slv_writedata 0x00000011.
REQ-028 Read 0x0040, PIT readdatavalid 2 cycles after ack with 0x000000AB -> avalon_io_readdatavalid one cycle, readdata 0x000000AB.
REQ-029 Read 0x0300 (unmapped) -> no slv strobe, readdatavalid with 0xFFFFFFFF two cycles after capture.
REQ-030 RTC holds waitrequest 1 forever on read 0x0070 -> forced ack after 255 stall cycles, readdata 0xFFFFFFFF, timeout_count 1.
REQ-031 Reset asserted in WAIT_DATA, PS/2 readdatavalid after release -> no avalon_io_readdatavalid, outputs at reset values.
REQ-032 Back-to-back write 0x00A0 then read 0x0064 -> second captured only after return to IDLE, strobes never overlap.
